wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_queue_if.sv | 12 +
 rtl/wb_queue_fifo.sv | 48 ++++
 rtl/wb_queue.sv | 81 ++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the write-back queue
package wb_pkg;
    localparam int WB_DEPTH  = 4;
    localparam int REG_NUM_W = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [REG_NUM_W-1:0] wn;
        logic [DATA_W-1:0]    wd;
    } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// rtl/wb_queue_if.sv - producer-side write-back offer handshake
interface wb_queue_if;
    import wb_pkg::*;

    logic                 in_valid;
    logic [REG_NUM_W-1:0] in_wn;
    logic [DATA_W-1:0]    in_wd;
    logic                 in_ready;

    modport master (output in_valid, output in_wn, output in_wd, input in_ready);
    modport slave  (input in_valid, input in_wn, input in_wd, output in_ready);
endinterface

// File: rtl/wb_queue_fifo.sv
// rtl/wb_queue_fifo.sv - write-back entry storage, pointers and occupancy
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = WB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wb_entry_t             push_data,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic [CW-1:0]         count,
    output wb_entry_t [DEPTH-1:0] age_entry,
    output logic [DEPTH-1:0]      age_valid
);
    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

    // Present occupied entries oldest-first so lookup can pick the youngest match.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entry[k] = mem[rd_ptr + PW'(k)];
            age_valid[k] = (CW'(k) < count);
        end
    end
endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - buffered register-file write-back with forwarding lookup
module wb_queue
    import wb_pkg::*;
#(
    parameter int  DEPTH = WB_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    wb_queue_if.slave            in_if,
    input  logic                 drain_en,
    output logic                 RegWrite,
    output logic [REG_NUM_W-1:0] WN,
    output logic [DATA_W-1:0]    WD,
    input  logic [REG_NUM_W-1:0] RN1,
    input  logic [REG_NUM_W-1:0] RN2,
    output logic                 fwd1_hit,
    output logic                 fwd2_hit,
    output logic [DATA_W-1:0]    fwd1_data,
    output logic [DATA_W-1:0]    fwd2_data,
    output logic [CW-1:0]        count
);
    logic                  push;
    logic                  pop;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] age_entry;
    logic [DEPTH-1:0]      age_valid;

    assign in_if.in_ready = (count != CW'(DEPTH));
    // Writes to register 0 are handshaken but never stored.
    assign push = in_if.in_valid && in_if.in_ready && (in_if.in_wn != '0);
    assign pop  = drain_en && (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ('{wn: in_if.in_wn, wd: in_if.in_wd}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .age_entry (age_entry),
        .age_valid (age_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite <= 1'b0;
            WN       <= '0;
            WD       <= '0;
        end else if (pop) begin
            RegWrite <= 1'b1;
            WN       <= head.wn;
            WD       <= head.wd;
        end else begin
            RegWrite <= 1'b0;
        end
    end

    // Output stage is oldest; queue entries scanned oldest to newest so the youngest wins.
    function automatic logic [DATA_W:0] lookup(
        input logic [REG_NUM_W-1:0] rn,
        input logic                 rw,
        input logic [REG_NUM_W-1:0] wn,
        input logic [DATA_W-1:0]    wd,
        input wb_entry_t [DEPTH-1:0] ents,
        input logic [DEPTH-1:0]     vld
    );
        logic [DATA_W:0] r;
        r = '0;
        if (rn != '0) begin
            if (rw && (wn == rn)) r = {1'b1, wd};
            for (int k = 0; k < DEPTH; k++)
                if (vld[k] && (ents[k].wn == rn)) r = {1'b1, ents[k].wd};
        end
        return r;
    endfunction

    assign {fwd1_hit, fwd1_data} = lookup(RN1, RegWrite, WN, WD, age_entry, age_valid);
    assign {fwd2_hit, fwd2_data} = lookup(RN2, RegWrite, WN, WD, age_entry, age_valid);
endmodule
